// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: types and constants shared by the memory request arbiter.
//   state_t : arbiter FSM state (IDLE / BUSY / GAP), 2 bits
//   gnt_t   : which requester owns the controller
//   OP_*    : memory opcodes as used by the LSB (mirrors const_def.v)
package mem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_ST   = 2'd1,
      GNT_LD   = 2'd2,
      GNT_IF   = 2'd3
   } gnt_t;

   localparam logic [6:0] OP_NOP = 7'd0;
   localparam logic [6:0] OP_LB  = 7'd1;
   localparam logic [6:0] OP_LH  = 7'd2;
   localparam logic [6:0] OP_LW  = 7'd3;
   localparam logic [6:0] OP_LBU = 7'd4;
   localparam logic [6:0] OP_LHU = 7'd5;
   localparam logic [6:0] OP_SB  = 7'd6;
   localparam logic [6:0] OP_SH  = 7'd7;
   localparam logic [6:0] OP_SW  = 7'd8;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational priority picker.
//   i_st_valid / i_ld_valid / i_if_valid : pending requests
//   i_flush    : blocks load and fetch for this pick
//   i_force_if : fetch has starved; fetch jumps ahead of store/load
//   o_grant    : chosen requester (GNT_NONE when nothing eligible)
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_st_valid,
   input  logic i_ld_valid,
   input  logic i_if_valid,
   input  logic i_flush,
   input  logic i_force_if,
   output gnt_t o_grant
);

   logic w_ld_ok;
   logic w_if_ok;

   // A flush kills speculative traffic only; stores are already committed.
   assign w_ld_ok = i_ld_valid & ~i_flush;
   assign w_if_ok = i_if_valid & ~i_flush;

   always_comb begin
      o_grant = GNT_NONE;
      if (i_force_if && w_if_ok) o_grant = GNT_IF;
      else if (i_st_valid)       o_grant = GNT_ST;
      else if (w_ld_ok)          o_grant = GNT_LD;
      else if (w_if_ok)          o_grant = GNT_IF;
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares the single-port memory controller between store
// (commit), load (LSB) and instruction fetch (i-cache).
//   clk, rst_n (async, active low), rdy (low freezes everything), flush
//   st_*  : store request in, st_done pulse out
//   ld_*  : load request in, ld_done pulse + ld_data out
//   if_*  : fetch request in, if_done pulse + if_data out
//   mc_*  : controller request (level until mc_valid) and completion inputs
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to force a fetch grant
// after STARVE_LIMIT consecutive store/load grants with fetch waiting.
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic              flush,
   input  logic              st_valid,
   input  logic [6:0]        st_op,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   output logic              st_done,
   input  logic              ld_valid,
   input  logic [6:0]        ld_op,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_done,
   output logic [DATA_W-1:0] ld_data,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_data,
   output logic              mc_enable,
   output logic              mc_fetch,
   output logic              mc_r_or_w,
   output logic [6:0]        mc_op,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [DATA_W-1:0] mc_data,
   input  logic              mc_valid,
   input  logic [DATA_W-1:0] mc_rdata
);

   state_t            r_state;
   state_t            w_state_nxt;
   gnt_t              r_kind;
   logic              r_cancel;
   logic              r_mc_enable;
   logic              r_mc_fetch;
   logic              r_mc_r_or_w;
   logic [6:0]        r_mc_op;
   logic [ADDR_W-1:0] r_mc_addr;
   logic [DATA_W-1:0] r_mc_data;
   logic              r_st_done;
   logic              r_ld_done;
   logic              r_if_done;
   logic [DATA_W-1:0] r_ld_data;
   logic [DATA_W-1:0] r_if_data;

   gnt_t              w_grant;
   gnt_t              w_take;
   logic              w_force_if;
   logic              w_kill;

   mem_arb_pick u_pick (
      .i_st_valid (st_valid),
      .i_ld_valid (ld_valid),
      .i_if_valid (if_valid),
      .i_flush    (flush),
      .i_force_if (w_force_if),
      .o_grant    (w_grant)
   );

   // Grant actually taken this cycle (picker output only matters in IDLE).
   assign w_take = (r_state == S_IDLE) ? w_grant : GNT_NONE;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   logic [SC_W-1:0] r_starve_cnt;

   assign w_force_if = (r_starve_cnt == SC_W'(STARVE_LIMIT));

   // Counts store/load wins while fetch waits; saturates at the limit so a
   // flush-blocked forced pick cannot wrap it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (rdy) begin
         if (!if_valid || w_take == GNT_IF)
            r_starve_cnt <= '0;
         else if ((w_take == GNT_ST || w_take == GNT_LD) && !w_force_if)
            r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end
`else
   // Strict priority: fetch is never forced. The limit stays in the
   // parameter list so both builds share one instantiation.
   assign w_force_if = (STARVE_LIMIT < 0);
`endif

   // A load/fetch response is dropped if a flush hit at any point while it
   // was outstanding, including the completion cycle itself.
   assign w_kill = r_cancel | (flush & (r_kind != GNT_ST));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   r_state <= S_IDLE;
      else if (rdy) r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_grant != GNT_NONE) w_state_nxt = S_BUSY;
         S_BUSY:  if (mc_valid) w_state_nxt = S_GAP;
         S_GAP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_kind      <= GNT_NONE;
         r_cancel    <= 1'b0;
         r_mc_enable <= 1'b0;
         r_mc_fetch  <= 1'b0;
         r_mc_r_or_w <= 1'b0;
         r_mc_op     <= '0;
         r_mc_addr   <= '0;
         r_mc_data   <= '0;
         r_st_done   <= 1'b0;
         r_ld_done   <= 1'b0;
         r_if_done   <= 1'b0;
         r_ld_data   <= '0;
         r_if_data   <= '0;
      end else if (rdy) begin
         r_st_done <= 1'b0;
         r_ld_done <= 1'b0;
         r_if_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant != GNT_NONE) begin
                  r_kind      <= w_grant;
                  r_cancel    <= 1'b0;
                  r_mc_enable <= 1'b1;
                  r_mc_fetch  <= (w_grant == GNT_IF);
                  r_mc_r_or_w <= (w_grant != GNT_ST);
                  case (w_grant)
                     GNT_ST: begin
                        r_mc_op   <= st_op;
                        r_mc_addr <= st_addr;
                        r_mc_data <= st_data;
                     end
                     GNT_LD: begin
                        r_mc_op   <= ld_op;
                        r_mc_addr <= ld_addr;
                        r_mc_data <= '0;
                     end
                     default: begin
                        r_mc_op   <= OP_NOP;
                        r_mc_addr <= if_addr;
                        r_mc_data <= '0;
                     end
                  endcase
               end
            end
            S_BUSY: begin
               if (flush && r_kind != GNT_ST) r_cancel <= 1'b1;
               if (mc_valid) begin
                  r_mc_enable <= 1'b0;
                  if (!w_kill) begin
                     case (r_kind)
                        GNT_ST: r_st_done <= 1'b1;
                        GNT_LD: begin
                           r_ld_done <= 1'b1;
                           r_ld_data <= mc_rdata;
                        end
                        GNT_IF: begin
                           r_if_done <= 1'b1;
                           r_if_data <= mc_rdata;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign st_done   = r_st_done;
   assign ld_done   = r_ld_done;
   assign ld_data   = r_ld_data;
   assign if_done   = r_if_done;
   assign if_data   = r_if_data;
   assign mc_enable = r_mc_enable;
   assign mc_fetch  = r_mc_fetch;
   assign mc_r_or_w = r_mc_r_or_w;
   assign mc_op     = r_mc_op;
   assign mc_addr   = r_mc_addr;
   assign mc_data   = r_mc_data;

endmodule
